// File: rtl/math_game_ctrl.sv
// Arithmetic quiz controller: password gate with lockout, operand draw from an
// external RNG, BCD countdown per round, scoring and end-of-game reporting.
module math_game_ctrl #(
  parameter int              DATA_W        = 4,
  parameter int              ROUNDS        = 8,
  parameter int              TICKS_PER_SEC = 50_000_000,
  parameter int              LOCK_TRIES    = 3,
  parameter logic [DATA_W-1:0] PWD_INIT    = 4'hA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pswd_in,
  input  logic              pswd_valid,
  input  logic              pswd_set,
  input  logic              start,
  input  logic              mode,
  input  logic [7:0]        time_limit,
  input  logic [DATA_W-1:0] rng_value,
  input  logic [DATA_W:0]   answer_in,
  input  logic              answer_valid,
  output logic              rng_req,
  output logic [DATA_W-1:0] operand_a,
  output logic [DATA_W-1:0] operand_b,
  output logic [3:0]        timer_tens,
  output logic [3:0]        timer_ones,
  output logic [7:0]        score,
  output logic [7:0]        round_cnt,
  output logic              green_led,
  output logic              red_led,
  output logic              game_over
);

  typedef enum logic [2:0] {
    LOCKED, IDLE, DRAW_A, DRAW_B, PLAY, RESULT, DONE, LOCKOUT
  } state_t;

  localparam int            TW       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_SEC - 1);

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t            state, state_nxt;
  logic [DATA_W-1:0] pwd;
  logic [7:0]        fail_cnt;
  logic              mode_q;
  logic              draw_ph;
  logic [TW-1:0]     tick_cnt;
  logic              green_q, red_q;

  logic              pwd_ok, timer_zero, tick_wrap, correct, lock_hit;
  logic [DATA_W:0]   expected;

  always_comb begin
    pwd_ok     = (pswd_in == pwd);
    timer_zero = (timer_tens == 4'd0) && (timer_ones == 4'd0);
    tick_wrap  = (tick_cnt == TICK_MAX);
    lock_hit   = (sat_inc(fail_cnt) >= 8'(LOCK_TRIES));
    if (mode_q)
      expected = (operand_a >= operand_b) ? {1'b0, operand_a - operand_b}
                                          : {1'b0, operand_b - operand_a};
    else
      expected = {1'b0, operand_a} + {1'b0, operand_b};
    correct = (answer_in == expected);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOCKED;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      LOCKED:  if (pswd_valid) state_nxt = pwd_ok ? IDLE : (lock_hit ? LOCKOUT : LOCKED);
      IDLE:    if (start && !pswd_set) state_nxt = DRAW_A;
      DRAW_A:  if (draw_ph) state_nxt = DRAW_B;
      DRAW_B:  if (draw_ph) state_nxt = PLAY;
      PLAY:    if (answer_valid || timer_zero) state_nxt = RESULT;
      RESULT:  if (tick_wrap) state_nxt = (round_cnt < 8'(ROUNDS)) ? DRAW_A : DONE;
      DONE:    if (start) state_nxt = DRAW_A;
      LOCKOUT: state_nxt = LOCKOUT;
      default: state_nxt = LOCKED;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    rng_req   = ((state == DRAW_A) || (state == DRAW_B)) && !draw_ph;
    game_over = (state == DONE);
    green_led = green_q;
    red_led   = red_q || (state == LOCKOUT);
  end

  // Datapath and bookkeeping registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwd        <= PWD_INIT;
      fail_cnt   <= '0;
      mode_q     <= 1'b0;
      draw_ph    <= 1'b0;
      tick_cnt   <= '0;
      operand_a  <= '0;
      operand_b  <= '0;
      timer_tens <= 4'd0;
      timer_ones <= 4'd0;
      score      <= 8'd0;
      round_cnt  <= 8'd0;
      green_q    <= 1'b0;
      red_q      <= 1'b0;
    end else begin
      draw_ph <= ((state == DRAW_A) || (state == DRAW_B)) ? ~draw_ph : 1'b0;
      case (state)
        LOCKED: begin
          if (pswd_valid) fail_cnt <= pwd_ok ? 8'd0 : sat_inc(fail_cnt);
        end
        IDLE, DONE: begin
          if ((state == IDLE) && pswd_set) pwd <= pswd_in;
          if (state_nxt == DRAW_A) begin
            score     <= 8'd0;
            round_cnt <= 8'd0;
            mode_q    <= mode;
          end
        end
        DRAW_A: begin
          if (draw_ph) operand_a <= rng_value;
        end
        DRAW_B: begin
          // RNG data arrives one cycle after the request; timer loads with it.
          if (draw_ph) begin
            operand_b  <= rng_value;
            timer_tens <= bcd_clamp(time_limit[7:4]);
            timer_ones <= bcd_clamp(time_limit[3:0]);
            tick_cnt   <= '0;
          end
        end
        PLAY: begin
          if (state_nxt == RESULT) begin
            tick_cnt  <= '0;
            round_cnt <= sat_inc(round_cnt);
            if (answer_valid && correct) begin
              green_q <= 1'b1;
              score   <= sat_inc(score);
            end else begin
              red_q <= 1'b1;
            end
          end else begin
            tick_cnt <= tick_wrap ? '0 : tick_cnt + TW'(1);
            if (tick_wrap) begin
              if (timer_ones == 4'd0) begin
                timer_ones <= 4'd9;
                timer_tens <= timer_tens - 4'd1;
              end else begin
                timer_ones <= timer_ones - 4'd1;
              end
            end
          end
        end
        RESULT: begin
          tick_cnt <= tick_cnt + TW'(1);
          if (state_nxt != RESULT) begin
            green_q <= 1'b0;
            red_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
